// File: rtl/gf180mcu_as_sc_mcu7t3v3__dfrtp_bank.sv
// WIDTH x STAGES bank of async-reset D flops with clock enable and a mux-D scan chain through every bit.
// Defining GF180MCU_AS_SC_MCU7T3V3_RETENTION_EN adds SAVE/RESTORE and a shadow (retention) array.
module gf180mcu_as_sc_mcu7t3v3__dfrtp_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGES = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VPW,
  input  logic             VNW,
  input  logic             VDD,
  input  logic             VSS,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             SE,
  input  logic             SI,
`ifdef GF180MCU_AS_SC_MCU7T3V3_RETENTION_EN
  input  logic             SAVE,
  input  logic             RESTORE,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             SO
);

  localparam int unsigned N = WIDTH * STAGES;
  localparam logic [N-1:0] RST_FLAT = {STAGES{RESET_VAL}};

  // Stage k occupies bits [k*WIDTH +: WIDTH], so the scan chain is a plain left shift of s.
  logic [N-1:0] s;
  logic [N-1:0] s_next;
  logic [N-1:0] shift_val;
  logic [N-1:0] cap_val;
  logic         unused_pwr;

  assign unused_pwr = &{1'b0, VPW, VNW, VDD, VSS};

  assign shift_val = (s << 1) | N'(SI);
  assign cap_val   = (s << WIDTH) | N'(D);

`ifdef GF180MCU_AS_SC_MCU7T3V3_RETENTION_EN
  logic [N-1:0] r;

  // Shadow state has no reset; during reset it samples the reset values held in s.
  always_ff @(posedge CLK) begin
    if (SAVE) begin
      r <= s;
    end
  end
`endif

  always_comb begin
    s_next = s;
    if (SE) begin
      s_next = shift_val;
    end else if (EN) begin
      s_next = cap_val;
    end
    // Unknown control poisons the whole bank rather than picking a branch.
    if ((SE ^ EN) === 1'bx) begin
      s_next = 'x;
    end
`ifdef GF180MCU_AS_SC_MCU7T3V3_RETENTION_EN
    if (RESTORE) begin
      s_next = r;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s <= RST_FLAT;
    end else begin
      s <= s_next;
    end
  end

  assign Q  = s[N-1 -: WIDTH];
  assign SO = s[N-1];

endmodule

// File: tb/tb_gf180mcu_as_sc_mcu7t3v3__dfrtp_bank.sv
// Bench for the flop bank at WIDTH=8, STAGES=3, RESET_VAL=8'hA5: vector table plus scan/reset/retention sequences.
module tb_gf180mcu_as_sc_mcu7t3v3__dfrtp_bank;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       VPW = 1'b0;
  logic       VNW = 1'b1;
  logic       VDD = 1'b1;
  logic       VSS = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] D = 8'h00;
  logic       SE = 1'b0;
  logic       SI = 1'b0;
`ifdef GF180MCU_AS_SC_MCU7T3V3_RETENTION_EN
  logic       SAVE = 1'b0;
  logic       RESTORE = 1'b0;
`endif
  logic [7:0] Q;
  logic       SO;

  int total = 0;
  int bad = 0;

  gf180mcu_as_sc_mcu7t3v3__dfrtp_bank #(
    .WIDTH(8),
    .STAGES(3),
    .RESET_VAL(8'hA5)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .VPW(VPW),
    .VNW(VNW),
    .VDD(VDD),
    .VSS(VSS),
    .EN(EN),
    .D(D),
    .SE(SE),
    .SI(SI),
`ifdef GF180MCU_AS_SC_MCU7T3V3_RETENTION_EN
    .SAVE(SAVE),
    .RESTORE(RESTORE),
`endif
    .Q(Q),
    .SO(SO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       en;
    logic       se;
    logic [7:0] d;
    logic       si;
    logic [7:0] q;
    logic       so;
  } vec_t;

  typedef struct packed {
    logic [7:0] q;
    logic       so;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];
  logic so_sb[$];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input logic se, input logic [7:0] d,
                              input logic si, input logic [7:0] q, input logic so);
    vec_t v;
    v.rst = rst; v.en = en; v.se = se; v.d = d; v.si = si; v.q = q; v.so = so;
    return v;
  endfunction

  task automatic mid_reset(input string name);
    RST = 1'b1;
    #2;
    chk8({name, "_q"}, Q, 8'hA5);
    chk1({name, "_so"}, SO, 1'b1);
    RST = 1'b0;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic [23:0] pat;
    logic [7:0] rev;
    logic bit_exp;

    // reset held across an edge with EN=1: reset must dominate
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 8'hA5, 1'b1);
    for (int i = 1; i <= 5; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 8'hA5, 1'b1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 8'hA5, 1'b1);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 8'hA5, 1'b1);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 8'h01, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 8'h02, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 8'h03, 1'b0);
    // gapped enable: 8'h22 is never captured
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 8'hA5, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 8'hA5, 1'b1);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 8'hA5, 1'b1);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 8'h11, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 8'h33, 1'b0);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 8'h44, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 8'h44, 1'b0);
    // SE and EN together: {44,55,66} shifts left by one -> {88,AA,CC}
    vecs[19] = mk(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h88, 1'b1);

    tick();

    for (int i = 0; i < 20; i++) begin
      v = vecs[i];
      if (v.rst) mid_reset($sformatf("vec%0d_async_rst", i));
      if (v.rst) RST = 1'b1;
      EN = v.en; SE = v.se; D = v.d; SI = v.si;
      sb.push_back('{q: v.q, so: v.so});
      tick();
      RST = 1'b0;
      e = sb.pop_front();
      chk8($sformatf("vec%0d_q", i), Q, e.q);
      chk1($sformatf("vec%0d_so", i), SO, e.so);
    end

    // scan chain: 24-bit pattern LSB first, SO replays it starting at edge 24
    mid_reset("scan_rst");
    pat = 24'hC35AF0;
    SE = 1'b1; EN = 1'b1; D = 8'hFF;
    for (int ed = 1; ed <= 48; ed++) begin
      SI = (ed <= 24) ? pat[ed-1] : 1'($urandom_range(0, 1));
      so_sb.push_back(SI);
      tick();
      if (ed >= 24) begin
        bit_exp = so_sb.pop_front();
        chk1($sformatf("scan_so_edge%0d", ed), SO, bit_exp);
      end
      if (ed == 24) begin
        for (int j = 0; j < 8; j++) rev[j] = pat[7-j];
        chk8("scan_q_after24", Q, rev);
      end
    end

    // reset in the middle of a shift, then shifting resumes
    mid_reset("shift_rst");
    SI = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk8("shift_resume_q", Q, 8'h5A);
    chk1("shift_resume_so", SO, 1'b0);
    SE = 1'b0; EN = 1'b0; SI = 1'b0;

`ifdef GF180MCU_AS_SC_MCU7T3V3_RETENTION_EN
    EN = 1'b1; D = 8'h3C;
    for (int k = 0; k < 3; k++) tick();
    EN = 1'b0;
    chk8("ret_load_q", Q, 8'h3C);
    SAVE = 1'b1; tick(); SAVE = 1'b0;
    mid_reset("ret_rst");
    RESTORE = 1'b1; SE = 1'b1; tick(); RESTORE = 1'b0; SE = 1'b0;
    chk8("ret_restore_q", Q, 8'h3C);
    mid_reset("ret_rst2");
    SAVE = 1'b1; RESTORE = 1'b1; tick(); SAVE = 1'b0;
    chk8("ret_swap_s_q", Q, 8'h3C);
    tick(); RESTORE = 1'b0;
    chk8("ret_swap_r_q", Q, 8'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
